// File: rtl/seq_window_gen_if.sv
// Control, window-configuration and status bundle for seq_window_gen.
// The master side drives control and configuration; the slave side returns counter status.
interface seq_window_gen_if #(
  parameter int CNT_W = 4,
  parameter int NCH   = 8
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             en;
  logic             mode_oneshot;
  logic             start;
  logic [CNT_W-1:0] period;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_lo;
  logic [CNT_W-1:0] cfg_hi;
  logic [CNT_W-1:0] count;
  logic [NCH-1:0]   ch_out;
  logic [NCH-1:0]   ch_rise;
  logic             wrap;
  logic             busy;
  logic             done;

  modport master (
    output en, mode_oneshot, start, period, cfg_we, cfg_ch, cfg_lo, cfg_hi,
    input  count, ch_out, ch_rise, wrap, busy, done
  );

  modport slave (
    input  en, mode_oneshot, start, period, cfg_we, cfg_ch, cfg_lo, cfg_hi,
    output count, ch_out, ch_rise, wrap, busy, done
  );
endinterface

// File: rtl/seq_window_gen.sv
// Sequence counter with free-running / one-shot modes and NCH programmable
// [lo, hi) count windows decoded combinationally from the running count.
module seq_window_gen #(
  parameter int CNT_W = 4,
  parameter int NCH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_window_gen_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] lo_q [NCH];
  logic [CNT_W-1:0] hi_q [NCH];
  logic [CNT_W-1:0] lo_d [NCH];
  logic [CNT_W-1:0] hi_d [NCH];
  logic             at_end;

  // Reload on >= so a period lowered below the current count still wraps at once.
  assign at_end = (count_q >= bus.period);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    if (!bus.en) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          count_d = '0;
          if (!bus.mode_oneshot || bus.start) begin
            state_d = RUN;
            mode_d  = bus.mode_oneshot;
          end
        end
        RUN: begin
          if (at_end) begin
            count_d = '0;
            if (mode_q) state_d = DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
          count_d = '0;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (bus.cfg_we && (32'(bus.cfg_ch) < NCH)) begin
      lo_d[bus.cfg_ch] = bus.cfg_lo;
      hi_d[bus.cfg_ch] = bus.cfg_hi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      mode_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        lo_q[i] <= '0;
        hi_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Window decode; an empty window (lo >= hi) can never satisfy lo <= count < hi.
  always_comb begin
    bus.ch_out  = '0;
    bus.ch_rise = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.ch_out[i]  = bus.busy && (lo_q[i] <= count_q) && (count_q < hi_q[i]);
      bus.ch_rise[i] = bus.busy && (count_q == lo_q[i]) && (lo_q[i] < hi_q[i]);
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.wrap  = bus.busy && at_end;
endmodule
